// File: rtl/collatz_seq_ctrl_if.sv
// Start/result bundle between the tile I/O (master) and the Collatz sequencer (slave).
interface collatz_seq_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8
);
    logic              start;
    logic [WIDTH-1:0]  seed;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  cur;
    logic [STEP_W-1:0] steps;
    logic [WIDTH-1:0]  peak;
    logic              ovf;
    logic              timeout;
    logic              zero_err;

    modport master (
        output start, seed,
        input  busy, done, cur, steps, peak, ovf, timeout, zero_err
    );

    modport slave (
        input  start, seed,
        output busy, done, cur, steps, peak, ovf, timeout, zero_err
    );
endinterface

// File: rtl/collatz_seq_ctrl.sv
// Start/busy/done engine iterating the Collatz step from a seed down to 1,
// tracking step count and peak, and stopping on overflow, step budget or zero seed.
module collatz_seq_ctrl #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    collatz_seq_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH+1:0]  MAX_VAL  = {2'b00, {WIDTH{1'b1}}};
    localparam logic [WIDTH-1:0]  ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_LIM = STEP_W'(MAX_STEPS);
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state_nxt;
    logic [WIDTH-1:0]  r_cur, w_cur_nxt, r_peak, w_peak_nxt;
    logic [STEP_W-1:0] r_steps, w_steps_nxt;
    logic              r_busy, w_busy_nxt, r_done, w_done_nxt;
    logic              r_ovf, w_ovf_nxt, r_timeout, w_timeout_nxt, r_zero, w_zero_nxt;
    logic [WIDTH+1:0]  w_tri;
    logic [WIDTH-1:0]  w_step_val;
    logic              w_ovf_hit;

    assign w_tri      = {2'b00, r_cur} + {2'b00, r_cur} + {2'b00, r_cur} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign w_step_val = r_cur[0] ? w_tri[WIDTH-1:0] : {1'b0, r_cur[WIDTH-1:1]};
    assign w_ovf_hit  = r_cur[0] && (w_tri > MAX_VAL);

    // Next-state and next-result selection.
    always_comb begin
        w_state_nxt   = r_state;
        w_cur_nxt     = r_cur;
        w_peak_nxt    = r_peak;
        w_steps_nxt   = r_steps;
        w_ovf_nxt     = r_ovf;
        w_timeout_nxt = r_timeout;
        w_zero_nxt    = r_zero;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cur_nxt     = bus.seed;
                    w_peak_nxt    = bus.seed;
                    w_steps_nxt   = {STEP_W{1'b0}};
                    w_ovf_nxt     = 1'b0;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                    // A zero seed takes one silent RUN cycle so done lands one edge after start.
                    w_zero_nxt    = (bus.seed == {WIDTH{1'b0}});
                    w_busy_nxt    = (bus.seed != {WIDTH{1'b0}});
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (r_cur <= ONE_VAL) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else if (r_steps == STEP_LIM) begin
                    w_state_nxt   = S_DONE;
                    w_done_nxt    = 1'b1;
                    w_timeout_nxt = 1'b1;
                end else if (w_ovf_hit) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_ovf_nxt   = 1'b1;
                end else begin
                    w_cur_nxt   = w_step_val;
                    w_steps_nxt = r_steps + STEP_ONE;
                    w_busy_nxt  = 1'b1;
                    if (w_step_val > r_peak) begin
                        w_peak_nxt = w_step_val;
                    end else begin
                        w_peak_nxt = r_peak;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cur     <= {WIDTH{1'b0}};
            r_peak    <= {WIDTH{1'b0}};
            r_steps   <= {STEP_W{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_timeout <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_peak    <= w_peak_nxt;
            r_steps   <= w_steps_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
            r_timeout <= w_timeout_nxt;
            r_zero    <= w_zero_nxt;
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.cur      = r_cur;
    assign bus.steps    = r_steps;
    assign bus.peak     = r_peak;
    assign bus.ovf      = r_ovf;
    assign bus.timeout  = r_timeout;
    assign bus.zero_err = r_zero;
endmodule

// File: doc/collatz_seq_ctrl.md
Name: collatz_seq_ctrl

Overview:
Sequencer that drives the Collatz step datapath (n -> n/2 if even, 3n+1 if odd, 1 is terminal) from a single seed until the value reaches 1. It counts steps, tracks the peak value, and flags arithmetic overflow or a step-budget timeout. It sits between the tile I/O and the step logic and turns a one-shot step into a start/busy/done iteration engine.

Parameters:
WIDTH, 8, datapath width of seed/current/peak values
STEP_W, 8, width of step counter
MAX_STEPS, 255, step budget; run aborts with timeout when reached (must be < 2^STEP_W)

Ports:
clk  input  1  clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
start  input  1  launch request; sampled only in IDLE
seed  input  WIDTH  starting value, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when a run finishes (any cause)
cur  output  WIDTH  current iterate (final value after done)
steps  output  STEP_W  steps executed
peak  output  WIDTH  maximum value seen, seed included
ovf  output  1  run ended because 3n+1 exceeded 2^WIDTH-1
timeout  output  1  run ended because steps reached MAX_STEPS
zero_err  output  1  run ended because seed was 0

Behaviour:
- All outputs registered. Reset (rst_n low at clk edge): state IDLE; busy, done, cur, steps, peak, ovf, timeout, zero_err all 0. Reset mid-run aborts immediately, no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> cur<=seed, peak<=seed, steps<=0, ovf/timeout/zero_err<=0. seed!=0 -> RUN (busy=1); seed==0 -> DONE with zero_err<=1. start=0 -> stay, results hold.
- RUN, one evaluation per cycle, priority order:
  1. cur==1 -> DONE, no flags.
  2. steps==MAX_STEPS -> DONE, timeout<=1, cur/steps unchanged.
  3. cur odd and 3*cur+1 > 2^WIDTH-1 (computed at WIDTH+2 bits) -> DONE, ovf<=1, cur/steps unchanged.
  4. else cur<=next, steps<=steps+1, peak<=max(peak,next).
- DONE: done=1 for exactly this cycle, busy=0 -> IDLE unconditionally. start in DONE is ignored.
- start while busy or in DONE: ignored, no queuing.
- Latency: start sampled at edge k -> done high after edge k+S+1 (S = final steps) on normal termination; seed 0 -> done after edge k+1.
- cur, steps, peak and the flags hold their final values until the next accepted start or reset. At most one of ovf/timeout/zero_err is set.
- steps never wraps (bounded by MAX_STEPS).

Test Plan:
- Seed 1: start for 1 cycle -> done one cycle after busy rises; steps=0, peak=1, cur=1, no flags; busy high exactly 1 cycle.
- Seed 6: done after edge k+9; steps=8, peak=16, cur=1. Seed 7 back-to-back after return to IDLE: steps=16, peak=52, cur=1.
- Seed 27 (WIDTH=8) -> ovf=1, steps=11, peak=214, cur=107. Seed 255 -> ovf=1, steps=0, peak=255, cur=255.
- MAX_STEPS=5, seed 6 -> timeout=1, steps=5, cur=8, peak=16, ovf=0.
- Seed 0 -> zero_err=1, done after edge k+1, busy never high. start pulsed during RUN of seed 7 with seed=3 -> ignored; results are for 7.
- Seed 7, drive rst_n low at step 4 for one edge -> all outputs 0, no done pulse. Then start seed 6 -> normal result (steps=8).
